// File: rtl/ram_pixel_streamer.sv
// Frame reader: pulls lines from the line RAM and streams them out as pixels.
// A one-line prefetch buffer hides the RAM read latency between lines.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           start-of-frame request (sampled in IDLE only)
//   o_rd, o_addr      RAM read enable / address
//   i_data            RAM read data, valid one cycle after o_rd
//   o_pixel           current pixel, o_pix_valid / i_pix_ready handshake
//   o_sof, o_last     first / last pixel of the frame
//   o_busy, o_done    frame in progress / one-cycle end-of-frame pulse
module ram_pixel_streamer #(
    parameter int LINE_W  = 48,
    parameter int PIX_W   = 3,
    parameter int ADDR_W  = 12,
    parameter int N_LINES = 3200
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_rd,
    output logic [ADDR_W-1:0] o_addr,
    input  logic [LINE_W-1:0] i_data,
    output logic [PIX_W-1:0]  o_pixel,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,
    output logic              o_sof,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam int PPL   = LINE_W / PIX_W;
    localparam int CNT_W = (PPL > 1) ? $clog2(PPL) : 1;

    localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(PPL - 1);
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(N_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LINE_W-1:0] shift_q;
    logic [LINE_W-1:0] pf_q;
    logic              shift_valid;
    logic              pf_full;
    logic              rd_pend;
    logic [CNT_W-1:0]  pix_cnt;
    logic [ADDR_W-1:0] line_cnt;
    logic [ADDR_W-1:0] addr_q;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              pix_valid;
    logic              xfer;
    logic              eol;
    logic              frame_end;

    assign pix_valid = (state == S_STREAM) && shift_valid;
    assign xfer      = pix_valid && i_pix_ready;
    assign eol       = xfer && (pix_cnt == PIX_LAST);
    assign frame_end = eol && (line_cnt == LINE_LAST);

    // addr_q is the address of the most recent read, so the next line
    // to fetch is always addr_q + 1 once the frame is under way.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_addr   = addr_q + ADDR_W'(1);
        unique case (state)
            S_IDLE: begin
                if (i_start) state_nxt = S_REQ;
            end
            S_REQ: begin
                rd_en     = 1'b1;
                rd_addr   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                rd_en = !pf_full && !rd_pend && (addr_q != LINE_LAST);
                if (frame_end) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_q     <= '0;
            pf_q        <= '0;
            shift_valid <= 1'b0;
            pf_full     <= 1'b0;
            rd_pend     <= 1'b0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            addr_q      <= '0;
        end else begin
            if (rd_en) addr_q <= rd_addr;

            if (state == S_IDLE && i_start) begin
                shift_valid <= 1'b0;
                pf_full     <= 1'b0;
                rd_pend     <= 1'b0;
                pix_cnt     <= '0;
                line_cnt    <= '0;
            end

            if (state == S_WAIT) begin
                shift_q     <= i_data;
                shift_valid <= 1'b1;
            end

            if (state == S_STREAM) begin
                rd_pend <= rd_en;

                if (xfer) begin
                    if (eol) begin
                        pix_cnt <= '0;
                        if (frame_end) begin
                            shift_valid <= 1'b0;
                        end else begin
                            line_cnt <= line_cnt + ADDR_W'(1);
                            if (pf_full) begin
                                shift_q <= pf_q;
                                pf_full <= 1'b0;
                            end else if (rd_pend) begin
                                // read lands on the switch cycle
                                shift_q <= i_data;
                            end else begin
                                shift_valid <= 1'b0;
                            end
                        end
                    end else begin
                        shift_q <= shift_q << PIX_W;
                        pix_cnt <= pix_cnt + CNT_W'(1);
                    end
                end

                // Read data not already consumed by a line switch.
                if (rd_pend && !(eol && !pf_full)) begin
                    if (!shift_valid) begin
                        shift_q     <= i_data;
                        shift_valid <= 1'b1;
                    end else begin
                        pf_q    <= i_data;
                        pf_full <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_rd        = rd_en;
    assign o_addr      = rd_en ? rd_addr : addr_q;
    assign o_pixel     = shift_q[LINE_W-1 -: PIX_W];
    assign o_pix_valid = pix_valid;
    assign o_sof       = pix_valid && (line_cnt == '0) && (pix_cnt == '0);
    assign o_last      = pix_valid && (line_cnt == LINE_LAST)
                         && (pix_cnt == PIX_LAST);
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);

endmodule

// File: tb/tb_ram_pixel_streamer.sv
// Directed bench for ram_pixel_streamer: 4-line instance for handshake,
// stall, reset and restart cases; default 3200-line instance for a full frame.
module tb_ram_pixel_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        ready;
    logic        rd_a;
    logic [11:0] addr_a;
    logic [47:0] data_a;
    logic [2:0]  pix_a;
    logic        val_a;
    logic        sof_a;
    logic        last_a;
    logic        busy_a;
    logic        done_a;

    logic        start_b;
    logic        ready_b;
    logic        rd_b;
    logic [11:0] addr_b;
    logic [47:0] data_b;
    logic [2:0]  pix_b;
    logic        val_b;
    logic        sof_b;
    logic        last_b;
    logic        busy_b;
    logic        done_b;

    int tests = 0;
    int fails = 0;

    ram_pixel_streamer #(
        .LINE_W(48), .PIX_W(3), .ADDR_W(12), .N_LINES(4)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_rd(rd_a), .o_addr(addr_a), .i_data(data_a),
        .o_pixel(pix_a), .o_pix_valid(val_a), .i_pix_ready(ready),
        .o_sof(sof_a), .o_last(last_a), .o_busy(busy_a), .o_done(done_a)
    );

    ram_pixel_streamer dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b),
        .o_rd(rd_b), .o_addr(addr_b), .i_data(data_b),
        .o_pixel(pix_b), .o_pix_valid(val_b), .i_pix_ready(ready_b),
        .o_sof(sof_b), .o_last(last_b), .o_busy(busy_b), .o_done(done_b)
    );

    function automatic logic [47:0] word_a(input logic [11:0] a);
        case (a)
            12'd0:   return 48'h0123_4567_89AB;
            12'd1:   return 48'hFEDC_BA98_7654;
            12'd2:   return 48'h5A5A_C3C3_0FF0;
            12'd3:   return 48'h9248_6DB6_E38E;
            default: return 48'h0;
        endcase
    endfunction

    function automatic logic [2:0] exp_pix_a(input int n);
        logic [47:0] w;
        int k;
        w = word_a(12'(n / 16));
        k = n % 16;
        return w[47 - 3 * k -: 3];
    endfunction

    function automatic logic [2:0] exp_pix_b(input int n);
        logic [11:0] l;
        logic [47:0] w;
        int k;
        l = 12'(n / 16);
        w = {l, l, l, l};
        k = n % 16;
        return w[47 - 3 * k -: 3];
    endfunction

    // 1-cycle latency RAM models
    always @(posedge clk) if (rd_a) data_a <= word_a(addr_a);
    always @(posedge clk) if (rd_b) data_b <= {addr_b, addr_b, addr_b, addr_b};

    // Runs one frame on dut_a and gathers observations; callers compare.
    task automatic run_frame(
        input  bit rnd,
        output int n_xfer, output int bad_pix, output int bubbles,
        output int rd_cnt, output int bad_addr, output int dbl_rd,
        output int flag_err, output int hold_err,
        output int done_lat, output int done_cnt
    );
        bit prev_rd, stalled, r;
        logic [2:0] h_pix;
        logic h_sof, h_last;
        int last_cyc, done_cyc;
        n_xfer = 0; bad_pix = 0; bubbles = 0; rd_cnt = 0; bad_addr = 0;
        dbl_rd = 0; flag_err = 0; hold_err = 0; done_lat = -1; done_cnt = 0;
        prev_rd = 0; stalled = 0; last_cyc = -1; done_cyc = -1;
        h_pix = '0; h_sof = 0; h_last = 0;
        ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (rd_a) begin
                if (addr_a !== 12'(rd_cnt)) bad_addr++;
                if (prev_rd) dbl_rd++;
                rd_cnt++;
            end
            prev_rd = rd_a;
            if (done_a) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    done_lat = cyc - last_cyc;
                end
            end
            if (val_a) begin
                if (pix_a !== exp_pix_a(n_xfer)) bad_pix++;
                if (sof_a !== (n_xfer == 0)) flag_err++;
                if (last_a !== (n_xfer == 63)) flag_err++;
                if (stalled && (pix_a !== h_pix || sof_a !== h_sof
                                || last_a !== h_last)) hold_err++;
            end else begin
                if (sof_a || last_a) flag_err++;
                if (stalled) hold_err++;
                if (n_xfer > 0 && n_xfer < 64) bubbles++;
            end
            r = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            ready = r;
            if (val_a && r) begin
                n_xfer++;
                last_cyc = cyc;
                stalled = 0;
            end else if (val_a) begin
                stalled = 1;
                h_pix = pix_a; h_sof = sof_a; h_last = last_a;
            end else begin
                stalled = 0;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(negedge clk);
        end
        ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b0;
        start_b = 1'b0; ready_b = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (rd_a !== 1'b0) begin
            fails++; $display("FAIL reset_rd: got %0b want 0", rd_a);
        end
        tests++;
        if (addr_a !== 12'd0) begin
            fails++; $display("FAIL reset_addr: got %0d want 0", addr_a);
        end
        tests++;
        if (pix_a !== 3'd0) begin
            fails++; $display("FAIL reset_pixel: got %0d want 0", pix_a);
        end
        tests++;
        if ({val_a, sof_a, last_a} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got %b want 000",
                              {val_a, sof_a, last_a});
        end
        tests++;
        if ({busy_a, done_a} !== 2'b00) begin
            fails++; $display("FAIL reset_busy_done: got %b want 00",
                              {busy_a, done_a});
        end
        tests++;
        if ({rd_b, val_b, busy_b, done_b} !== 4'b0000) begin
            fails++; $display("FAIL reset_b: got %b want 0000",
                              {rd_b, val_b, busy_b, done_b});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy_a !== 1'b0) begin
            fails++; $display("FAIL idle_no_start: busy %0b want 0", busy_a);
        end
    endtask

    task automatic test_first_pixels();
        int i;
        ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        tests++;
        if ({rd_a, addr_a, val_a, busy_a} !== {1'b1, 12'd0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL req_cycle: rd %0b addr %0d valid %0b busy %0b want 1 0 0 1",
                              rd_a, addr_a, val_a, busy_a);
        end
        @(negedge clk);
        tests++;
        if ({rd_a, val_a} !== 2'b00) begin
            fails++; $display("FAIL wait_cycle: rd %0b valid %0b want 0 0",
                              rd_a, val_a);
        end
        @(negedge clk);
        tests++;
        if ({val_a, pix_a, sof_a} !== {1'b1, 3'b000, 1'b1}) begin
            fails++; $display("FAIL pix0: valid %0b pixel %b sof %0b want 1 000 1",
                              val_a, pix_a, sof_a);
        end
        @(negedge clk);
        tests++;
        if ({val_a, pix_a, sof_a} !== {1'b1, 3'b000, 1'b0}) begin
            fails++; $display("FAIL pix1: valid %0b pixel %b sof %0b want 1 000 0",
                              val_a, pix_a, sof_a);
        end
        @(negedge clk);
        tests++;
        if ({val_a, pix_a, sof_a} !== {1'b1, 3'b010, 1'b0}) begin
            fails++; $display("FAIL pix2: valid %0b pixel %b sof %0b want 1 010 0",
                              val_a, pix_a, sof_a);
        end
        for (i = 0; i < 200 && !done_a; i++) @(negedge clk);
        tests++;
        if (done_a !== 1'b1) begin
            fails++; $display("FAIL first_frame_done: timeout, done %0b want 1", done_a);
        end
        @(negedge clk);
    endtask

    task automatic test_stream();
        int nx, bp, bb, rc, ba, dr, fe, he, dl, dc;
        run_frame(0, nx, bp, bb, rc, ba, dr, fe, he, dl, dc);
        tests++;
        if (nx != 64) begin fails++; $display("FAIL stream_xfers: got %0d want 64", nx); end
        tests++;
        if (bp != 0) begin fails++; $display("FAIL stream_pixels: %0d wrong, want 0", bp); end
        tests++;
        if (bb != 0) begin fails++; $display("FAIL stream_bubbles: got %0d want 0", bb); end
        tests++;
        if (rc != 4 || ba != 0) begin
            fails++; $display("FAIL stream_reads: count %0d bad addr %0d want 4 0", rc, ba);
        end
        tests++;
        if (fe != 0) begin fails++; $display("FAIL stream_sof_last: %0d errors want 0", fe); end
        tests++;
        if (dl != 1 || dc != 1) begin
            fails++; $display("FAIL stream_done: latency %0d count %0d want 1 1", dl, dc);
        end
    endtask

    task automatic test_back_to_back_stall();
        int nx, bp, bb, rc, ba, dr, fe, he, dl, dc;
        run_frame(1, nx, bp, bb, rc, ba, dr, fe, he, dl, dc);
        tests++;
        if (nx != 64 || bp != 0) begin
            fails++; $display("FAIL stall_sequence: xfers %0d bad %0d want 64 0", nx, bp);
        end
        tests++;
        if (he != 0) begin fails++; $display("FAIL stall_hold: %0d errors want 0", he); end
        tests++;
        if (dr != 0 || rc != 4 || ba != 0) begin
            fails++; $display("FAIL stall_reads: dbl %0d count %0d bad %0d want 0 4 0",
                              dr, rc, ba);
        end
        tests++;
        if (fe != 0 || dc != 1) begin
            fails++; $display("FAIL stall_flags_done: flag err %0d done %0d want 0 1", fe, dc);
        end
    endtask

    task automatic test_reset_abort();
        int n, dcnt, rcnt;
        bit hit;
        int nx, bp, bb, rc, ba, dr, fe, he, dl, dc;
        n = 0; hit = 0; dcnt = 0; rcnt = 0;
        ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (val_a && n == 20) begin
                hit = 1;
                break;
            end
            if (val_a) n++;
        end
        ready = 1'b0;
        @(negedge clk);
        tests++;
        if (!hit || val_a !== 1'b1 || pix_a !== exp_pix_a(20)) begin
            fails++; $display("FAIL abort_stalled_pix20: reached %0b valid %0b pixel %b want 1 1 %b",
                              hit, val_a, pix_a, exp_pix_a(20));
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({rd_a, addr_a, pix_a, val_a, sof_a, last_a, busy_a, done_a} !== 20'd0) begin
            fails++; $display("FAIL abort_outputs: got %h want 0",
                              {rd_a, addr_a, pix_a, val_a, sof_a, last_a, busy_a, done_a});
        end
        rst = 1'b0;
        ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done_a) dcnt++;
            if (rd_a) rcnt++;
        end
        tests++;
        if (dcnt != 0 || rcnt != 0) begin
            fails++; $display("FAIL abort_quiet: done %0d rd %0d want 0 0", dcnt, rcnt);
        end
        run_frame(0, nx, bp, bb, rc, ba, dr, fe, he, dl, dc);
        tests++;
        if (nx != 64 || bp != 0 || ba != 0 || dc != 1) begin
            fails++; $display("FAIL abort_restart: xfers %0d bad %0d badaddr %0d done %0d want 64 0 0 1",
                              nx, bp, ba, dc);
        end
    endtask

    task automatic test_start_ignored();
        int dcnt, rcnt, a0, nx;
        dcnt = 0; rcnt = 0; a0 = 0; nx = 0;
        ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rd_a) begin
                rcnt++;
                if (addr_a == 12'd0) a0++;
            end
            if (done_a) dcnt++;
            if (val_a) nx++;
            start = (c == 10 || c == 40);
            @(negedge clk);
        end
        start = 1'b0;
        tests++;
        if (dcnt != 1 || nx != 64) begin
            fails++; $display("FAIL busy_start_frames: done %0d xfers %0d want 1 64", dcnt, nx);
        end
        tests++;
        if (rcnt != 4 || a0 != 1 || busy_a !== 1'b0) begin
            fails++; $display("FAIL busy_start_reads: rd %0d addr0 %0d busy %0b want 4 1 0",
                              rcnt, a0, busy_a);
        end
    endtask

    task automatic test_full_frame();
        int n, bad, lerr;
        bit seen;
        n = 0; bad = 0; lerr = 0; seen = 0;
        ready_b = 1'b1;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int c = 0; c < 52000; c++) begin
            if (done_b) begin
                seen = 1;
                break;
            end
            if (val_b) begin
                if (pix_b !== exp_pix_b(n)) bad++;
                if (last_b !== (n == 51199)) lerr++;
                n++;
            end
            @(negedge clk);
        end
        tests++;
        if (n != 51200 || !seen) begin
            fails++; $display("FAIL full_frame_xfers: got %0d done %0b want 51200 1", n, seen);
        end
        tests++;
        if (bad != 0 || lerr != 0) begin
            fails++; $display("FAIL full_frame_data: bad %0d last err %0d want 0 0", bad, lerr);
        end
        tests++;
        if (addr_b !== 12'd3199) begin
            fails++; $display("FAIL full_frame_addr: got %0d want 3199", addr_b);
        end
    endtask

    initial begin
        test_reset();
        test_first_pixels();
        test_stream();
        test_back_to_back_stall();
        test_reset_abort();
        test_start_ignored();
        test_full_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
